// File: rtl/bp_resolve_queue.sv
// Branch resolve queue: holds in-flight perceptron predictions in program
// order, checks each against the execute-stage outcome and produces a
// registered redirect/flush plus a registered perceptron training packet.
//
// Handshake: a record is accepted on a rising edge when push=1 and either the
// queue is not full or a pop happens in the same cycle (and that pop does not
// flush). A record is popped when res_valid=1 and the queue is not empty.
// Every result output is registered, so it appears one cycle after the pop.
module bp_resolve_queue #(
    parameter int DEPTH  = 4,
    parameter int W_BITS = 8,
    parameter int THETA  = 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [31:0]       push_pc,
    input  logic              push_taken,
    input  logic [W_BITS-1:0] push_y,
    input  logic [31:0]       push_target,
    output logic              full,
    output logic              empty,
    input  logic              res_valid,
    input  logic [31:0]       res_pc,
    input  logic              res_br_en,
    input  logic [31:0]       res_target,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              train_valid,
    output logic [31:0]       train_pc,
    output logic              train_taken,
    output logic [W_BITS-1:0] train_y,
    output logic              ghr_shift,
    output logic              seq_err,
    output logic [15:0]       br_count,
    output logic [15:0]       mispred_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] C_FULL = (PW + 1)'(DEPTH);
    localparam logic [W_BITS:0] C_THETA = (W_BITS + 1)'(THETA);

    // Record storage; contents after reset are don't-care.
    logic [31:0]       r_pc_mem  [DEPTH];
    logic              r_tk_mem  [DEPTH];
    logic [W_BITS-1:0] r_y_mem   [DEPTH];
    logic [31:0]       r_tgt_mem [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic              w_pop;
    logic              w_pc_ok;
    logic              w_good_pop;
    logic              w_mispred;
    logic              w_flush;
    logic              w_push_acc;
    logic              w_seq_bad;
    logic [31:0]       w_h_pc;
    logic              w_h_tk;
    logic [W_BITS-1:0] w_h_y;
    logic [31:0]       w_h_tgt;
    logic [W_BITS:0]   w_y_ext;
    logic [W_BITS:0]   w_y_mag;
    logic              w_small_y;

    assign full  = (r_count == C_FULL);
    assign empty = (r_count == '0);

    assign w_h_pc  = r_pc_mem[r_head];
    assign w_h_tk  = r_tk_mem[r_head];
    assign w_h_y   = r_y_mem[r_head];
    assign w_h_tgt = r_tgt_mem[r_head];

    // A PC mismatch still consumes the head but produces no result.
    assign w_pop      = res_valid && !empty;
    assign w_pc_ok    = (w_h_pc == res_pc);
    assign w_good_pop = w_pop && w_pc_ok;
    assign w_seq_bad  = res_valid && (empty || !w_pc_ok);

    assign w_mispred = (w_h_tk != res_br_en) || (res_br_en && (w_h_tgt != res_target));
    assign w_flush   = w_good_pop && w_mispred;

    // A push in a flushing cycle is younger than the branch, so it is lost.
    assign w_push_acc = push && (!full || w_pop) && !w_flush;

    // Magnitude is one bit wider so the most-negative y does not wrap.
    assign w_y_ext   = {w_h_y[W_BITS-1], w_h_y};
    assign w_y_mag   = w_y_ext[W_BITS] ? (~w_y_ext + 1'b1) : w_y_ext;
    assign w_small_y = (w_y_mag < C_THETA);

    // Write accepted records at the tail slot.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_pc_mem[r_tail]  <= push_pc;
            r_tk_mem[r_tail]  <= push_taken;
            r_y_mem[r_tail]   <= push_y;
            r_tgt_mem[r_tail] <= push_target;
        end
    end

    // Pointer and occupancy update; a flush empties the queue behind the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= r_head + 1'b1;
            r_tail  <= r_head + 1'b1;
            r_count <= '0;
        end else begin
            if (w_pop)      r_head <= r_head + 1'b1;
            if (w_push_acc) r_tail <= r_tail + 1'b1;
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered resolve results: pulses for one cycle, data held between pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            train_valid   <= 1'b0;
            train_pc      <= '0;
            train_taken   <= 1'b0;
            train_y       <= '0;
            ghr_shift     <= 1'b0;
            seq_err       <= 1'b0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            redirect    <= w_flush;
            train_valid <= w_good_pop && (w_mispred || w_small_y);
            ghr_shift   <= w_good_pop;
            if (w_seq_bad) seq_err <= 1'b1;
            if (w_good_pop) begin
                redirect_pc <= res_br_en ? res_target : (w_h_pc + 32'd4);
                train_pc    <= w_h_pc;
                train_taken <= res_br_en;
                train_y     <= w_h_y;
                if (br_count != 16'hFFFF) br_count <= br_count + 16'd1;
                if (w_mispred && (mispred_count != 16'hFFFF))
                    mispred_count <= mispred_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Bench for bp_resolve_queue: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_bp_resolve_queue;

  localparam int DEPTH = 4;
  localparam int W_BITS = 8;
  localparam int THETA = 37;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              push = 1'b0;
  logic [31:0]       push_pc = '0;
  logic              push_taken = 1'b0;
  logic [W_BITS-1:0] push_y = '0;
  logic [31:0]       push_target = '0;
  logic              full, empty;
  logic              res_valid = 1'b0;
  logic [31:0]       res_pc = '0;
  logic              res_br_en = 1'b0;
  logic [31:0]       res_target = '0;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              train_valid;
  logic [31:0]       train_pc;
  logic              train_taken;
  logic [W_BITS-1:0] train_y;
  logic              ghr_shift;
  logic              seq_err;
  logic [15:0]       br_count;
  logic [15:0]       mispred_count;

  bp_resolve_queue #(.DEPTH(DEPTH), .W_BITS(W_BITS), .THETA(THETA)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_pc(push_pc), .push_taken(push_taken), .push_y(push_y),
    .push_target(push_target), .full(full), .empty(empty),
    .res_valid(res_valid), .res_pc(res_pc), .res_br_en(res_br_en), .res_target(res_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .train_valid(train_valid),
    .train_pc(train_pc), .train_taken(train_taken), .train_y(train_y),
    .ghr_shift(ghr_shift), .seq_err(seq_err), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  // reference model: in-flight records plus expected registered outputs
  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [7:0]  y;
    logic [31:0] tg;
  } rec_t;

  rec_t        mq[$];
  logic        e_redirect, e_tv, e_tt, e_ghr, e_seq;
  logic [31:0] e_rpc, e_tpc;
  logic [7:0]  e_ty;
  logic [15:0] e_br, e_mp;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_redirect = 0; e_tv = 0; e_tt = 0; e_ghr = 0; e_seq = 0;
    e_rpc = '0; e_tpc = '0; e_ty = '0; e_br = '0; e_mp = '0;
  endtask

  task automatic check_all();
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("redirect", 32'(redirect), 32'(e_redirect));
    check("redirect_pc", redirect_pc, e_rpc);
    check("train_valid", 32'(train_valid), 32'(e_tv));
    check("train_pc", train_pc, e_tpc);
    check("train_taken", 32'(train_taken), 32'(e_tt));
    check("train_y", 32'(train_y), 32'(e_ty));
    check("ghr_shift", 32'(ghr_shift), 32'(e_ghr));
    check("seq_err", 32'(seq_err), 32'(e_seq));
    check("br_count", 32'(br_count), 32'(e_br));
    check("mispred_count", 32'(mispred_count), 32'(e_mp));
  endtask

  // driver: apply one cycle of inputs, predict, clock, compare
  task automatic step(input logic p, input logic [31:0] ppc, input logic ptk,
                      input logic [7:0] py, input logic [31:0] ptg,
                      input logic rv, input logic [31:0] rpc, input logic ben,
                      input logic [31:0] rtg);
    rec_t h;
    bit   pop_req, good, mis, flush, acc;
    int   yi;
    push = p; push_pc = ppc; push_taken = ptk; push_y = py; push_target = ptg;
    res_valid = rv; res_pc = rpc; res_br_en = ben; res_target = rtg;
    pop_req = rv && (mq.size() != 0);
    good = 0; mis = 0;
    e_redirect = 0; e_tv = 0; e_ghr = 0;
    if (rv && (mq.size() == 0 || mq[0].pc != rpc)) e_seq = 1;
    if (pop_req) begin
      h = mq[0];
      good = (h.pc == rpc);
    end
    if (good) begin
      mis = (h.tk != ben) || (ben && h.tg != rtg);
      yi = int'($signed(h.y));
      if (yi < 0) yi = -yi;
      e_ghr = 1;
      e_redirect = mis;
      e_rpc = ben ? rtg : h.pc + 32'd4;
      e_tv = mis || (yi < THETA);
      e_tpc = h.pc; e_tt = ben; e_ty = h.y;
      if (e_br != 16'hFFFF) e_br = e_br + 16'd1;
      if (mis && e_mp != 16'hFFFF) e_mp = e_mp + 16'd1;
    end
    flush = good && mis;
    acc = p && (mq.size() < DEPTH || pop_req) && !flush;
    if (pop_req) void'(mq.pop_front());
    if (flush) mq.delete();
    if (acc) mq.push_back('{pc: ppc, tk: ptk, y: py, tg: ptg});
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [31:0] head_pc();
    return (mq.size() != 0) ? mq[0].pc : 32'hDEAD_0000;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_push(input logic [31:0] pc, input logic tk, input logic [7:0] y,
                         input logic [31:0] tg);
    step(1, pc, tk, y, tg, 0, 0, 0, 0);
  endtask

  task automatic do_res(input logic ben, input logic [31:0] tg);
    step(0, 0, 0, 0, 0, 1, head_pc(), ben, tg);
  endtask

  initial begin
    model_reset();
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    idle(1);

    // fill, drop a 5th push, drain correct not-taken with y=-50
    for (int i = 0; i < 4; i++) do_push(32'h60 + 32'(4 * i), 0, 8'hCE, 32'h0);
    check("plan1_full", 32'(full), 32'd1);
    do_push(32'h70, 0, 8'hCE, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_res(0, 32'h0);
      check("plan1_ghr", 32'(ghr_shift), 32'd1);
      check("plan1_tv", 32'(train_valid), 32'd0);
    end
    check("plan1_br", 32'(br_count), 32'd4);
    check("plan1_empty", 32'(empty), 32'd1);
    idle(1);

    // not-taken prediction resolved taken
    do_push(32'h80, 0, 8'hFD, 32'h0);
    do_res(1, 32'h100);
    check("plan2_redirect", 32'(redirect), 32'd1);
    check("plan2_rpc", redirect_pc, 32'h100);
    check("plan2_tv", 32'(train_valid), 32'd1);
    check("plan2_tt", 32'(train_taken), 32'd1);
    check("plan2_mp", 32'(mispred_count), 32'd1);

    // wrong target, younger records and same-cycle push flushed
    do_push(32'h90, 1, 8'd60, 32'h200);
    for (int i = 0; i < 3; i++) do_push(32'h200 + 32'(4 * i), 0, 8'd60, 32'h0);
    step(1, 32'hA0, 0, 8'd60, 32'h0, 1, 32'h90, 1, 32'h204);
    check("plan3_rpc", redirect_pc, 32'h204);
    check("plan3_empty", 32'(empty), 32'd1);
    idle(1);

    // training threshold boundaries
    do_push(32'hB0, 0, 8'd36, 32'h0);
    do_res(0, 32'h0);
    check("plan4_tv36", 32'(train_valid), 32'd1);
    do_push(32'hB4, 0, 8'd37, 32'h0);
    do_res(0, 32'h0);
    check("plan4_tv37", 32'(train_valid), 32'd0);
    do_push(32'hB8, 0, 8'h80, 32'h0);
    do_res(0, 32'h0);
    check("plan4_tv_neg128", 32'(train_valid), 32'd0);
    do_push(32'hBC, 0, 8'hDC, 32'h0);  // y = -36
    do_res(0, 32'h0);
    check("plan4_tv_neg36", 32'(train_valid), 32'd1);

    // randomized traffic, resolves always in order with the correct PC
    for (int i = 0; i < 400; i++) begin
      logic        p, tk, rv, ben;
      logic [31:0] pc, tg, rtg;
      p = 1'($urandom_range(0, 1));
      tk = 1'($urandom_range(0, 1));
      pc = 32'({$urandom_range(0, 65535), 2'b00});
      tg = 32'({$urandom_range(0, 3), 4'h0});
      rv = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
      ben = 1'($urandom_range(0, 1));
      rtg = (mq.size() != 0 && $urandom_range(0, 1) == 1) ? mq[0].tg
            : 32'({$urandom_range(0, 3), 4'h0});
      step(p, pc, tk, 8'($urandom), tg, rv, head_pc(), ben, rtg);
    end
    while (mq.size() != 0) do_res(mq[0].tk, mq[0].tg);

    // full queue with concurrent push and pop, pointers wrap
    for (int i = 0; i < 4; i++) do_push(32'h300 + 32'(4 * i), 1, 8'd90, 32'h400);
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h310 + 32'(4 * i), 1, 8'd90, 32'h400, 1, head_pc(), 1, 32'h400);
      check("plan5_full", 32'(full), 32'd1);
      check("plan5_redirect", 32'(redirect), 32'd0);
    end
    while (mq.size() != 0) do_res(1, 32'h400);

    // PC mismatch pops head without results
    do_push(32'h500, 0, 8'd0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h504, 0, 0);
    check("plan5_mismatch_seq", 32'(seq_err), 32'd1);
    check("plan5_mismatch_ghr", 32'(ghr_shift), 32'd0);
    check("plan5_mismatch_empty", 32'(empty), 32'd1);
    // resolve on empty, seq_err stays set
    do_res(0, 0);
    check("plan5_seq", 32'(seq_err), 32'd1);
    idle(3);
    check("plan5_seq_sticky", 32'(seq_err), 32'd1);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) do_push(32'h600 + 32'(4 * i), 1, 8'd5, 32'h700);
    step(0, 0, 0, 0, 0, 1, head_pc(), 0, 0);  // mispredict leaves pulses high
    for (int i = 0; i < 3; i++) do_push(32'h610 + 32'(4 * i), 1, 8'd5, 32'h700);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    check("plan6_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1;
    check_all();
    push = 1'b0; res_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    check("plan6_no_redirect", 32'(redirect), 32'd0);
    do_push(32'h800, 0, 8'd1, 32'h0);
    do_res(0, 32'h0);
    check("plan6_after_br", 32'(br_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
